// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register bank and its clear sequencer.
package reg_bank_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_PW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_bank_clr.sv
// Clear sequencer: sweeps a pointer across every bank entry, then signals done for one cycle.
module reg_bank_clr
    import reg_bank_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] ptr,
    output logic          clr_we
);

    clr_state_t state, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && clr_start) begin
                ptr <= '0;
            end else if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        clr_we  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // The pointer wraps to zero on the same edge that leaves CLEAR.
                if (ptr == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Two-read, one-write register bank with optional hard-wired zero entry, write bypass
// and a sequenced whole-bank clear.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int PW      = DEF_PW,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam int DEPTH = 1 << PW;

    logic [DW-1:0] core [DEPTH];
    logic [PW-1:0] clr_ptr;
    logic          clr_we;
    logic          wr_zero;
    logic          wr_commit;
    logic          byp_ok;

    reg_bank_clr #(.PW(PW)) u_clr (
        .clk       (clk),
        .reset     (reset),
        .clr_start (clr_start),
        .busy      (clr_busy),
        .done      (clr_done),
        .ptr       (clr_ptr),
        .clr_we    (clr_we)
    );

    assign wr_zero   = ZERO_R0 && (wr_addr == '0);
    assign wr_commit = wr_en && !clr_busy && !wr_zero;
    assign byp_ok    = BYPASS && wr_commit && !reset;
    assign wr_drop   = wr_en && clr_busy;

    // NOTE: the array is reset because an asynchronous whole-bank zero is part of its contract.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                core[i] <= '0;
            end
        end else if (clr_we) begin
            core[clr_ptr] <= '0;
        end else if (wr_commit) begin
            core[wr_addr] <= dat_in;
        end
    end

    always_comb begin
        datA_out = core[rd_addrA];
        datB_out = core[rd_addrB];
        if (byp_ok && rd_addrA == wr_addr) begin
            datA_out = dat_in;
        end
        if (byp_ok && rd_addrB == wr_addr) begin
            datB_out = dat_in;
        end
        if (ZERO_R0 && rd_addrA == '0) begin
            datA_out = '0;
        end
        if (ZERO_R0 && rd_addrB == '0) begin
            datB_out = '0;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: bypass, zero entry, clear sweep, drops and reset.
module tb_reg_bank;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] dat_in;
    logic [3:0] rd_addrA;
    logic [3:0] rd_addrB;
    logic       clr_start;
    logic [7:0] datA_out, datB_out;
    logic       clr_busy, clr_done, wr_drop;
    logic [7:0] nb_datA, nb_datB;
    logic       nb_busy, nb_done, nb_drop;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_mem [16];

    reg_bank u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .dat_in    (dat_in),
        .rd_addrA  (rd_addrA),
        .rd_addrB  (rd_addrB),
        .datA_out  (datA_out),
        .datB_out  (datB_out),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wr_drop   (wr_drop)
    );

    reg_bank #(.BYPASS(1'b0)) u_dut_nb (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .dat_in    (dat_in),
        .rd_addrA  (rd_addrA),
        .rd_addrB  (rd_addrB),
        .datA_out  (nb_datA),
        .datB_out  (nb_datB),
        .clr_start (clr_start),
        .clr_busy  (nb_busy),
        .clr_done  (nb_done),
        .wr_drop   (nb_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        dat_in  = d;
        tick();
        wr_en = 1'b0;
        if (a != 4'd0) exp_mem[a] = d;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addrB = 4'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), datB_out, exp_mem[i]);
            tick();
        end
    endtask

    // Call one cycle after the edge that accepted clr_start.
    task automatic follow_sweep(input string tag, input int drop_at, input logic [3:0] da,
                                input logic [7:0] old_val);
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        rd_addrB = 4'd3;
        for (int c = 1; c <= 20; c++) begin
            if (c == drop_at) begin
                wr_en    = 1'b1;
                wr_addr  = da;
                dat_in   = 8'h3C;
                rd_addrA = da;
            end
            if (c == 10) clr_start = 1'b1;
            #1;
            if (clr_busy) busy_cnt++;
            if (clr_done && done_at == 0) done_at = c;
            if (c == drop_at) begin
                check({tag, " wr_drop"}, wr_drop, 1'b1);
                check({tag, " bypass off"}, datA_out, old_val);
            end
            if (c == 4) check({tag, " unswept entry 3"}, datB_out, exp_mem[3]);
            if (c == 5) check({tag, " swept entry 3"}, datB_out, 8'h00);
            tick();
            wr_en     = 1'b0;
            clr_start = 1'b0;
        end
        check({tag, " busy cycles"}, busy_cnt, 17);
        check({tag, " done cycle"}, done_at, 17);
        check({tag, " busy after"}, clr_busy, 1'b0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    endtask

    initial begin
        logic seen_done;
        logic seen_busy;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; dat_in = '0;
        rd_addrA = '0; rd_addrB = '0; clr_start = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset state
        #7;
        check("rst clr_busy", clr_busy, 1'b0);
        check("rst clr_done", clr_done, 1'b0);
        check("rst wr_drop", wr_drop, 1'b0);
        rd_addrA = 4'd5; rd_addrB = 4'd9;
        #1;
        check("rst datA", datA_out, 8'h00);
        check("rst datB", datB_out, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Write-then-read with and without bypass
        wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5; rd_addrA = 4'd3; rd_addrB = 4'd3;
        #1;
        check("bypass datA", datA_out, 8'hA5);
        check("no-bypass old datA", nb_datA, 8'h00);
        tick();
        wr_en = 1'b0; exp_mem[3] = 8'hA5;
        #1;
        check("after write datA", datA_out, 8'hA5);
        check("no-bypass after write", nb_datA, 8'hA5);
        tick();

        // Hard-wired zero entry
        wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'hFF; rd_addrA = 4'd0; rd_addrB = 4'd0;
        #1;
        check("r0 write datA", datA_out, 8'h00);
        check("r0 write datB", datB_out, 8'h00);
        check("r0 write wr_drop", wr_drop, 1'b0);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0 after datA", datA_out, 8'h00);
        check("r0 after nb datB", nb_datB, 8'h00);
        tick();

        // Fill the bank and read back; ports A and B on different addresses
        for (int i = 1; i < 16; i++) wr(4'(i), 8'(8'h30 + i));
        wr(4'd0, 8'hEE);
        rd_addrA = 4'd5; rd_addrB = 4'd12;
        #1;
        check("dual read A", datA_out, 8'h35);
        check("dual read B", datB_out, 8'h3C);
        tick();
        check_all("fill");

        // Full clear sweep, with a second clr_start ignored mid-sweep
        clr_start = 1'b1;
        #1;
        check("start still idle", clr_busy, 1'b0);
        tick();
        clr_start = 1'b0;
        follow_sweep("sweep", 0, 4'd0, 8'h00);
        check_all("after sweep");

        // Write during clear is dropped and does not bypass
        wr(4'd9, 8'h77);
        wr(4'd3, 8'h55);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        follow_sweep("drop", 5, 4'd9, 8'h77);
        check_all("after drop");

        // Simultaneous start and write: write commits, then gets swept
        wr(4'd2, 8'h22);
        clr_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; dat_in = 8'h11; rd_addrA = 4'd2;
        #1;
        check("simul bypass", datA_out, 8'h11);
        check("simul wr_drop", wr_drop, 1'b0);
        tick();
        clr_start = 1'b0; wr_en = 1'b0;
        #1;
        check("simul committed", datA_out, 8'h11);
        #1;
        follow_sweep("simul", 0, 4'd0, 8'h00);
        check_all("after simul");

        // Reset in the middle of a sweep
        wr(4'd7, 8'h5A);
        wr(4'd14, 8'hC3);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        rd_addrA = 4'd14; rd_addrB = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h99;
        #1;
        check("mid-sweep datA", datA_out, 8'hC3);
        check("mid-sweep datB", datB_out, 8'h5A);
        check("mid-sweep wr_drop", wr_drop, 1'b1);
        reset = 1'b1;
        #1;
        check("async rst busy", clr_busy, 1'b0);
        check("async rst done", clr_done, 1'b0);
        check("async rst wr_drop", wr_drop, 1'b0);
        check("async rst datA", datA_out, 8'h00);
        check("async rst datB", datB_out, 8'h00);
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (clr_done) seen_done = 1'b1;
            if (clr_busy) seen_busy = 1'b1;
        end
        check("aborted no done", seen_done, 1'b0);
        check("aborted idle", seen_busy, 1'b0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        check_all("after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter PW, default 4, address width in bits; depth = 2**PW entries.
REQ-003 Parameter ZERO_R0, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write enable.
REQ-008 wr_addr  input  PW  write address.
REQ-009 dat_in  input  DW  write data.
REQ-010 rd_addrA  input  PW  read address, port A.
REQ-011 rd_addrB  input  PW  read address, port B.
REQ-012 datA_out  output  DW  read data, port A (combinational).
REQ-013 datB_out  output  DW  read data, port B (combinational).
REQ-014 clr_start  input  1  single-cycle request to zero the whole bank.
REQ-015 clr_busy  output  1  high while the clear sweep is in progress.
REQ-016 clr_done  output  1  one-cycle pulse when the sweep completes.
REQ-017 wr_drop  output  1  one-cycle pulse when a write is discarded because of clear.

Function
REQ-018 Reads SHALL be combinational: datX_out = core[rd_addrX], with no cycle of latency.
REQ-019 With ZERO_R0=1, a read of address 0 SHALL return 0 on both ports, and a write to address 0 SHALL be discarded without asserting wr_drop.
REQ-020 A write SHALL update core[wr_addr] with dat_in on posedge clk when wr_en=1 and the FSM is in IDLE.
REQ-021 With BYPASS=1, when wr_en=1, FSM=IDLE, wr_addr==rd_addrX and the address is not a suppressed address 0, datX_out SHALL equal dat_in in the same cycle.
REQ-022 With BYPASS=0, a read SHALL return the old contents until the edge after the write.
REQ-023 The clear FSM SHALL have three states: IDLE, CLEAR and DONE.
REQ-024 IDLE->CLEAR SHALL occur on clr_start=1; this edge loads the sweep pointer with 0.
REQ-025 In CLEAR, each clock SHALL write 0 to core[ptr] and increment ptr by 1.
REQ-026 CLEAR->DONE SHALL occur on the edge that clears entry 2**PW-1, so the sweep occupies exactly 2**PW cycles.
REQ-027 DONE->IDLE SHALL occur unconditionally after one cycle; clr_done=1 only in DONE.
REQ-028 clr_busy SHALL be 1 in CLEAR and DONE, and 0 in IDLE.
REQ-029 clr_start SHALL be ignored in CLEAR and DONE, so a new sweep cannot be queued.
REQ-030 wr_en=1 in CLEAR or DONE SHALL discard the write, pulse wr_drop=1 that cycle, and disable bypass.
REQ-031 If clr_start and wr_en are both high in IDLE, the write SHALL commit and the sweep SHALL start on the same edge, so the write is later overwritten by the sweep.
REQ-032 Reads during CLEAR SHALL return array contents: 0 for entries already swept, old data for the rest.
REQ-033 ptr SHALL be PW bits wide, and its wrap from 2**PW-1 to 0 SHALL coincide with the exit from CLEAR.

Reset
REQ-034 Asserting reset SHALL immediately and asynchronously zero all core entries, set the FSM to IDLE and set ptr to 0.
REQ-035 While reset is asserted, clr_busy, clr_done and wr_drop SHALL be 0, and datA_out and datB_out SHALL be 0.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse.

Structure
REQ-037 Package reg_bank_pkg SHALL hold the clear-state enum (IDLE, CLEAR, DONE) and the default DW and PW constants.
REQ-038 The clear FSM and pointer SHALL live in sub-module reg_bank_clr (ports: clk, reset, clr_start; outputs: busy, done, ptr, clr_we); the storage array stays in reg_bank.

Verification
REQ-039 Write-then-read: write 8'hA5 to addr 3 -> next cycle, datA_out=8'hA5; with BYPASS=1, datA_out=8'hA5 already in the write cycle.
REQ-040 Zero register: ZERO_R0=1, write 8'hFF to addr 0 -> datA_out=datB_out=0 and wr_drop=0.
REQ-041 Clear sweep: fill all 16 entries with nonzero values, pulse clr_start -> clr_busy=1 for 17 cycles, clr_done pulses in cycle 17, then all reads return 0.
REQ-042 Write during clear: wr_en=1 at sweep cycle 5 to addr 9 with 8'h3C -> wr_drop=1, and after done, addr 9 reads 0.
REQ-043 Simultaneous start and write: clr_start=1 with wr_en=1 to addr 2 with 8'h11 -> the bank is all zero after clr_done.
REQ-044 Reset mid-sweep: assert reset at sweep cycle 7 -> outputs go to 0 at once, no clr_done pulse, FSM in IDLE, all entries 0.
